// File: rtl/sequence_detector_param.sv
// sequence_detector_param
//
// Watches a stream of SYM_W-bit symbols and pulses `pattern` for one clock
// when the last SEQ_LEN accepted symbols equal a runtime-programmable target.
// Supports overlapping or non-overlapping matches, keeps a saturating match
// counter, and reports how many valid symbols are currently in the window.
//
// Optional feature (macro SEQDET_MASK_EN): adds a per-position don't-care
// mask, written through cfg_mask alongside cfg_sym.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_valid     number is accepted on this edge
//   number       input symbol (SYM_W bits)
//   overlap_en   1 = overlapping matches allowed
//   cfg_we       target-symbol write strobe (has priority over in_valid)
//   cfg_idx      index of the target symbol to write
//   cfg_sym      new target symbol value
//   cfg_mask     (SEQDET_MASK_EN only) don't-care bit for position cfg_idx
//   pattern      registered one-cycle match pulse
//   progress     valid symbols currently in the window, 0..SEQ_LEN
//   match_count  saturating count of matches
module sequence_detector_param #(
  parameter int SYM_W = 4,
  parameter int SEQ_LEN = 4,
  parameter int CNT_W = 8,
  parameter logic [SYM_W*SEQ_LEN-1:0] DEFAULT_PAT = 16'h1010,
  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int PROG_W = $clog2(SEQ_LEN + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [SYM_W-1:0]  number,
  input  logic              overlap_en,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [SYM_W-1:0]  cfg_sym,
`ifdef SEQDET_MASK_EN
  input  logic              cfg_mask,
`endif
  output logic              pattern,
  output logic [PROG_W-1:0] progress,
  output logic [CNT_W-1:0]  match_count
);

  localparam int WIN_W = SYM_W * SEQ_LEN;
  localparam logic [IDX_W:0] LEN_C = (IDX_W + 1)'(SEQ_LEN);
  localparam logic [PROG_W-1:0] FULL = PROG_W'(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIN_W-1:0]  window_q, window_next, shifted;
  logic [WIN_W-1:0]  target_q, target_next;
  logic [PROG_W-1:0] fill_q, fill_next, fill_inc;
  logic [CNT_W-1:0]  count_q, count_next;
  logic              pattern_q;
  logic              cfg_hit, match_all, pos_eq, hit;
`ifdef SEQDET_MASK_EN
  logic [SEQ_LEN-1:0] mask_q, mask_next;
`endif

  // Oldest symbol lives at index 0, so the new symbol enters at the top and
  // the window lines up with the target's "symbol 0 arrives first" layout.
  assign shifted = {number, window_q[WIN_W-1:SYM_W]};

  // Out-of-range indices are treated as no write at all, letting in_valid
  // through as if cfg_we were low.
  assign cfg_hit = cfg_we && ({1'b0, cfg_idx} < LEN_C);

  // Next-state logic. The comparison always uses the target held before the
  // edge; a config write in the same cycle wins and drops any input symbol.
  always_comb begin
    window_next = window_q;
    target_next = target_q;
    fill_next   = fill_q;
    fill_inc    = fill_q;
    count_next  = count_q;
    match_all   = 1'b1;
    pos_eq      = 1'b1;
    hit         = 1'b0;
`ifdef SEQDET_MASK_EN
    mask_next   = mask_q;
`endif

    for (int i = 0; i < SEQ_LEN; i++) begin
      pos_eq = (shifted[i*SYM_W +: SYM_W] == target_q[i*SYM_W +: SYM_W]);
`ifdef SEQDET_MASK_EN
      pos_eq = pos_eq || mask_q[i];
`endif
      if (!pos_eq) match_all = 1'b0;
    end

    if (cfg_hit) begin
      for (int i = 0; i < SEQ_LEN; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          target_next[i*SYM_W +: SYM_W] = cfg_sym;
`ifdef SEQDET_MASK_EN
          mask_next[i] = cfg_mask;
`endif
        end
      end
      fill_next = '0;
    end else if (in_valid) begin
      window_next = shifted;
      fill_inc    = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      hit         = (fill_inc == FULL) && match_all;
      // Non-overlap mode restarts the fill so the next match needs a fully
      // fresh set of symbols; overlap mode keeps the window as-is.
      fill_next   = (hit && !overlap_en) ? '0 : fill_inc;
    end

    if (hit && (count_q != CNT_MAX)) count_next = count_q + 1'b1;
  end

  // State register; reset also kills a pattern pulse already in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      window_q  <= '0;
      target_q  <= DEFAULT_PAT;
      fill_q    <= '0;
      count_q   <= '0;
      pattern_q <= 1'b0;
`ifdef SEQDET_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      window_q  <= window_next;
      target_q  <= target_next;
      fill_q    <= fill_next;
      count_q   <= count_next;
      pattern_q <= hit;
`ifdef SEQDET_MASK_EN
      mask_q    <= mask_next;
`endif
    end
  end

  assign pattern     = pattern_q;
  assign progress    = fill_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
// tb_sequence_detector_param
//
// Directed bench for sequence_detector_param. Three instances share one set
// of inputs: dut_a uses default parameters, dut_b has a 2-bit counter for
// saturation, and dut_c has SEQ_LEN=3 (target 0,1,0) so that cfg_idx=3 is an
// out-of-range index. Each instance is only checked in its own segment, and
// every segment starts from a fresh reset.
module tb_sequence_detector_param;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] number;
  logic       overlap_en;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_sym;
`ifdef SEQDET_MASK_EN
  logic       cfg_mask;
`endif

  logic       pattern_a, pattern_b, pattern_c;
  logic [2:0] progress_a, progress_b;
  logic [1:0] progress_c;
  logic [7:0] count_a, count_c;
  logic [1:0] count_b;

  int checks = 0;
  int errors = 0;
  int exp_cnt [5] = '{1, 2, 3, 3, 3};
  int hit_no;

  sequence_detector_param dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .number(number),
    .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
`ifdef SEQDET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .pattern(pattern_a), .progress(progress_a), .match_count(count_a)
  );

  sequence_detector_param #(.CNT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .number(number),
    .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
`ifdef SEQDET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .pattern(pattern_b), .progress(progress_b), .match_count(count_b)
  );

  sequence_detector_param #(.SEQ_LEN(3), .DEFAULT_PAT(12'h010)) dut_c (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .number(number),
    .overlap_en(overlap_en), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sym(cfg_sym),
`ifdef SEQDET_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .pattern(pattern_c), .progress(progress_c), .match_count(count_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one input cycle, then sample just after the active edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] sym);
    in_valid = valid;
    number   = sym;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Write one target symbol (cfg_mask is taken from its current value).
  task automatic cfgWrite(input logic [1:0] idx, input logic [3:0] sym);
    cfg_we  = 1'b1;
    cfg_idx = idx;
    cfg_sym = sym;
    @(posedge clock);
    #1;
    cfg_we  = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic doReset();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    reset_n  = 1'b0;
    #2;
    reset_n  = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; number = '0; overlap_en = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_sym = '0;
`ifdef SEQDET_MASK_EN
    cfg_mask = 1'b0;
`endif
    #3;
    checkOutput("rst_pattern", 32'(pattern_a), 0);
    checkOutput("rst_progress", 32'(progress_a), 0);
    checkOutput("rst_count", 32'(count_a), 0);
    #9 reset_n = 1'b1;

    // Mid-stream asynchronous reset
    applyStimulus(1, 0); applyStimulus(1, 1); applyStimulus(1, 0);
    checkOutput("pre_rst_progress", 32'(progress_a), 3);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_progress", 32'(progress_a), 0);
    checkOutput("async_rst_pattern", 32'(pattern_a), 0);
    checkOutput("async_rst_count", 32'(count_a), 0);
    reset_n = 1'b1;
    applyStimulus(1, 1);
    checkOutput("post_rst_pattern", 32'(pattern_a), 0);
    checkOutput("post_rst_progress", 32'(progress_a), 1);

    // Reset kills a pulse in flight
    doReset();
    applyStimulus(1, 0); applyStimulus(1, 1); applyStimulus(1, 0); applyStimulus(1, 1);
    checkOutput("flight_pattern", 32'(pattern_a), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("flight_rst_pattern", 32'(pattern_a), 0);
    checkOutput("flight_rst_count", 32'(count_a), 0);
    reset_n = 1'b1;

    // Non-overlap: 0,1,0,1,0,1
    doReset(); overlap_en = 1'b0;
    applyStimulus(1, 0); checkOutput("nov_pat1", 32'(pattern_a), 0); checkOutput("nov_prog1", 32'(progress_a), 1);
    applyStimulus(1, 1); checkOutput("nov_pat2", 32'(pattern_a), 0); checkOutput("nov_prog2", 32'(progress_a), 2);
    applyStimulus(1, 0); checkOutput("nov_pat3", 32'(pattern_a), 0); checkOutput("nov_prog3", 32'(progress_a), 3);
    applyStimulus(1, 1); checkOutput("nov_pat4", 32'(pattern_a), 1); checkOutput("nov_prog4", 32'(progress_a), 0);
    applyStimulus(1, 0); checkOutput("nov_pat5", 32'(pattern_a), 0); checkOutput("nov_prog5", 32'(progress_a), 1);
    applyStimulus(1, 1); checkOutput("nov_pat6", 32'(pattern_a), 0); checkOutput("nov_prog6", 32'(progress_a), 2);
    checkOutput("nov_count", 32'(count_a), 1);

    // Overlap: same stream
    doReset(); overlap_en = 1'b1;
    applyStimulus(1, 0); applyStimulus(1, 1); applyStimulus(1, 0);
    checkOutput("ov_pat3", 32'(pattern_a), 0);
    applyStimulus(1, 1); checkOutput("ov_pat4", 32'(pattern_a), 1); checkOutput("ov_prog4", 32'(progress_a), 4);
    applyStimulus(1, 0); checkOutput("ov_pat5", 32'(pattern_a), 0); checkOutput("ov_prog5", 32'(progress_a), 4);
    applyStimulus(1, 1); checkOutput("ov_pat6", 32'(pattern_a), 1);
    checkOutput("ov_count", 32'(count_a), 2);

    // Gaps with junk on number while idle
    doReset(); overlap_en = 1'b0;
    applyStimulus(1, 0);
    for (int g = 0; g < 3; g++) applyStimulus(0, 4'hF);
    checkOutput("gap_prog1", 32'(progress_a), 1);
    applyStimulus(1, 1);
    for (int g = 0; g < 3; g++) applyStimulus(0, 4'hF);
    checkOutput("gap_prog2", 32'(progress_a), 2);
    applyStimulus(1, 0);
    for (int g = 0; g < 3; g++) applyStimulus(0, 4'hF);
    checkOutput("gap_prog3", 32'(progress_a), 3);
    checkOutput("gap_nopat", 32'(pattern_a), 0);
    applyStimulus(1, 1);
    checkOutput("gap_pat", 32'(pattern_a), 1);
    applyStimulus(0, 4'hF);
    checkOutput("gap_pat_end", 32'(pattern_a), 0);
    checkOutput("gap_count", 32'(count_a), 1);

    // Reprogram to 9,4,4,1
    doReset();
    cfgWrite(0, 9); cfgWrite(1, 4); cfgWrite(2, 4); cfgWrite(3, 1);
    applyStimulus(1, 9); applyStimulus(1, 4); applyStimulus(1, 4);
    checkOutput("rp_pat3", 32'(pattern_a), 0);
    applyStimulus(1, 1);
    checkOutput("rp_pat4", 32'(pattern_a), 1);
    checkOutput("rp_count", 32'(count_a), 1);
    applyStimulus(1, 9); applyStimulus(1, 4);
    checkOutput("rp_prog_pre", 32'(progress_a), 2);
    in_valid = 1'b1; number = 4'd9;
    cfgWrite(0, 9);
    checkOutput("cfg_drop_prog", 32'(progress_a), 0);
    checkOutput("cfg_drop_pat", 32'(pattern_a), 0);
    checkOutput("cfg_keep_count", 32'(count_a), 1);
    applyStimulus(1, 4); applyStimulus(1, 4); applyStimulus(1, 1);
    checkOutput("cfg_drop_nopat", 32'(pattern_a), 0);
    checkOutput("cfg_drop_prog3", 32'(progress_a), 3);

    // Saturation on the 2-bit counter instance
    doReset(); overlap_en = 1'b1;
    hit_no = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 4'(i % 2));
      if (i >= 3 && (i % 2) == 1) begin
        checkOutput("sat_pat", 32'(pattern_b), 1);
        checkOutput("sat_count", 32'(count_b), 32'(exp_cnt[hit_no]));
        hit_no++;
      end else begin
        checkOutput("sat_nopat", 32'(pattern_b), 0);
      end
    end

    // Out-of-range index on the SEQ_LEN=3 instance: write ignored, symbol kept
    doReset(); overlap_en = 1'b0;
    in_valid = 1'b1; number = 4'd0;
    cfgWrite(3, 7);
    checkOutput("oor_prog", 32'(progress_c), 1);
    applyStimulus(1, 1);
    applyStimulus(1, 0);
    checkOutput("oor_pat", 32'(pattern_c), 1);
    checkOutput("oor_count", 32'(count_c), 1);

`ifdef SEQDET_MASK_EN
    // Mask position 1 as don't-care, then clear it again
    doReset(); overlap_en = 1'b0;
    cfg_mask = 1'b1; cfgWrite(1, 1); cfg_mask = 1'b0;
    applyStimulus(1, 0); applyStimulus(1, 7); applyStimulus(1, 0); applyStimulus(1, 1);
    checkOutput("mask_pat", 32'(pattern_a), 1);
    cfgWrite(1, 1);
    applyStimulus(1, 0); applyStimulus(1, 7); applyStimulus(1, 0); applyStimulus(1, 1);
    checkOutput("unmask_nopat", 32'(pattern_a), 0);
    checkOutput("unmask_prog", 32'(progress_a), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
